// File: rtl/serial_alu_pkg.sv
// serial_alu_pkg
//   Shared definitions for the bit-serial ALU: opcode encoding used by the
//   controller and the per-bit slice, and the controller FSM state type.
package serial_alu_pkg;

    // Opcode values 9..15 have no name. They are treated as invalid and
    // produce a zero result with no carry.
    typedef enum logic [3:0] {
        OP_AND    = 4'd0,
        OP_OR     = 4'd1,
        OP_XOR    = 4'd2,
        OP_NOT_A  = 4'd3,
        OP_NOT_B  = 4'd4,
        OP_ADD    = 4'd5,
        OP_SUB    = 4'd6,
        OP_PASS_A = 4'd7,
        OP_PASS_B = 4'd8
    } opcode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_alu_slice.sv
// serial_alu_slice
//   Purely combinational 1-bit ALU slice. The controller feeds it one operand
//   bit pair per clock, LSB first, together with the running carry/borrow.
// Ports
//   a, b  : operand bits
//   cin   : carry (ADD) or borrow (SUB) from the previous, lower bit
//   sel   : opcode
//   s     : result bit
//   cout  : carry/borrow into the next bit; 0 for non-arithmetic opcodes
module serial_alu_slice
    import serial_alu_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    input  logic [3:0] sel,
    output logic       s,
    output logic       cout
);

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        s    = 1'b0;
        cout = 1'b0;
        case (sel)
            OP_AND:    s = a & b;
            OP_OR:     s = a | b;
            OP_XOR:    s = a ^ b;
            OP_NOT_A:  s = ~a;
            OP_NOT_B:  s = ~b;
            OP_ADD: begin
                s    = a ^ b ^ cin;
                cout = (a & b) | (a & cin) | (b & cin);
            end
            OP_SUB: begin
                // Borrow out when a < b + borrow-in at this bit position.
                s    = a ^ b ^ cin;
                cout = (~a & b) | (~(a ^ b) & cin);
            end
            OP_PASS_A: s = a;
            OP_PASS_B: s = b;
            default: begin
                s    = 1'b0;
                cout = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/serial_alu_ctrl.sv
// serial_alu_ctrl
//   Bit-serial ALU controller. A request is accepted in IDLE, then the 1-bit
//   slice is stepped over WIDTH bits, LSB first, one bit per clock in RUN.
//   The finished result is presented in DONE until the consumer takes it.
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   in_valid, in_ready  : request handshake (in_ready high only in IDLE)
//   a, b, sel           : operands and opcode, captured at the accepting edge
//   out_valid, out_ready: result handshake (out_valid high only in DONE)
//   result, carry, zero : result word, carry/borrow flag, result == 0 flag
//   busy                : high while the operation is running
module serial_alu_ctrl
    import serial_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             busy
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [3:0]       op_q;
    logic [IDX_W-1:0] idx;
    logic             slice_s;
    logic             slice_cout;

    serial_alu_slice u_slice (
        .a    (a_q[idx]),
        .b    (b_q[idx]),
        .cin  (carry),
        .sel  (op_q),
        .s    (slice_s),
        .cout (slice_cout)
    );

    assign zero = (result == '0);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // flop samples pre-edge values regardless of statement order.
        if (rst) begin
            state     <= ST_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            idx       <= '0;
            result    <= '0;
            carry     <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_q      <= a;
                        b_q      <= b;
                        op_q     <= sel;
                        idx      <= '0;
                        result   <= '0;
                        carry    <= 1'b0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // The slice forces cout low for non-arithmetic opcodes,
                    // so carry stays 0 for them without a separate check.
                    result[idx] <= slice_s;
                    carry       <= slice_cout;
                    idx         <= idx + IDX_W'(1);
                    if (idx == LAST_IDX) begin
                        idx       <= '0;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// tb_serial_alu_ctrl
//   Directed self-checking bench for serial_alu_ctrl (WIDTH = 8). Inputs are
//   driven 1 time unit after a rising edge and outputs sampled at the same
//   point, so nothing changes near the active edge.
module tb_serial_alu_ctrl;
    import serial_alu_pkg::*;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       sel;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             zero;
    logic             busy;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    serial_alu_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry     (carry),
        .zero      (zero),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request in IDLE and step past the accepting edge, then
    // scramble the inputs to show they are no longer looked at.
    task automatic start(input logic [3:0] op, input logic [7:0] av, input logic [7:0] bv);
        in_valid = 1'b1;
        a        = av;
        b        = bv;
        sel      = op;
        tick();
        in_valid = 1'b0;
        a        = ~av;
        b        = ~bv;
        sel      = 4'd1;
    endtask

    // Count edges from the accepting edge until out_valid, bounded.
    task automatic wait_done(input string tag);
        int lat = 0;
        while (!out_valid && lat < WIDTH + 4) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, lat, WIDTH);
    endtask

    task automatic run_op(input string tag, input logic [3:0] op,
                          input logic [7:0] av, input logic [7:0] bv,
                          input logic [7:0] er, input logic ec);
        start(op, av, bv);
        check({tag, "_busy"}, busy, 1);
        check({tag, "_in_ready_run"}, in_ready, 0);
        wait_done(tag);
        check({tag, "_result"}, result, er);
        check({tag, "_carry"}, carry, ec);
        check({tag, "_zero"}, zero, (er == 8'h00));
        tick();
        check({tag, "_back_idle"}, in_ready, 1);
    endtask

    // out_valid and in_ready must never be high together.
    always @(negedge clk) begin
        if (rst === 1'b0)
            check("exclusive_handshake", out_valid & in_ready, 0);
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        sel       = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        check("reset_in_ready",  in_ready,  1);
        check("reset_out_valid", out_valid, 0);
        check("reset_busy",      busy,      0);
        check("reset_result",    result,    0);
        check("reset_carry",     carry,     0);
        check("reset_zero",      zero,      1);

        run_op("add_ff_01",  OP_ADD,    8'hFF, 8'h01, 8'h00, 1'b1);
        run_op("sub_05_07",  OP_SUB,    8'h05, 8'h07, 8'hFE, 1'b1);
        run_op("sub_07_05",  OP_SUB,    8'h07, 8'h05, 8'h02, 1'b0);
        run_op("xor_a5_ff",  OP_XOR,    8'hA5, 8'hFF, 8'h5A, 1'b0);
        run_op("not_b_0f",   OP_NOT_B,  8'h33, 8'h0F, 8'hF0, 1'b0);
        run_op("pass_a_3c",  OP_PASS_A, 8'h3C, 8'h81, 8'h3C, 1'b0);
        run_op("and_a5_3c",  OP_AND,    8'hA5, 8'h3C, 8'h24, 1'b0);
        run_op("or_a5_3c",   OP_OR,     8'hA5, 8'h3C, 8'hBD, 1'b0);
        run_op("not_a_0f",   OP_NOT_A,  8'h0F, 8'h55, 8'hF0, 1'b0);
        run_op("pass_b_3c",  OP_PASS_B, 8'h99, 8'h3C, 8'h3C, 1'b0);
        run_op("add_3c_0f",  OP_ADD,    8'h3C, 8'h0F, 8'h4B, 1'b0);
        run_op("sub_00_00",  OP_SUB,    8'h00, 8'h00, 8'h00, 1'b0);
        run_op("invalid_15", 4'd15,     8'hFF, 8'hFF, 8'h00, 1'b0);
        run_op("invalid_9",  4'd9,      8'hFF, 8'h01, 8'h00, 1'b0);

        // Backpressure: DONE holds while out_ready is low; new requests ignored.
        out_ready = 1'b0;
        start(OP_ADD, 8'h3C, 8'h0F);
        wait_done("bp");
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            a        = 8'h11;
            b        = 8'h22;
            sel      = OP_AND;
            tick();
            check("bp_hold_result",    result,    8'h4B);
            check("bp_hold_out_valid", out_valid, 1);
            check("bp_hold_in_ready",  in_ready,  0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_release_out_valid", out_valid, 0);
        check("bp_release_in_ready",  in_ready,  1);
        tick();
        check("bp_no_queued_op", busy, 0);

        // Reset while bit 3 is being processed discards the operation.
        start(OP_SUB, 8'h05, 8'h07);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_run_out_valid", out_valid, 0);
        check("rst_run_result",    result,    0);
        check("rst_run_in_ready",  in_ready,  1);
        check("rst_run_busy",      busy,      0);
        check("rst_run_zero",      zero,      1);
        run_op("after_rst_add", OP_ADD, 8'h80, 8'h80, 8'h00, 1'b1);

        // Reset while sitting in DONE.
        out_ready = 1'b0;
        start(OP_XOR, 8'hF0, 8'h0F);
        wait_done("rst_done");
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        out_ready = 1'b1;
        check("rst_done_out_valid", out_valid, 0);
        check("rst_done_result",    result,    0);
        check("rst_done_in_ready",  in_ready,  1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
